// File: rtl/disp_scan4.sv
// Four-digit multiplexed 7-segment scanner: staged value transfers to the
// displayed register only at frame boundaries; per-slot nibble/point/anode drive.
module disp_scan4 #(
  parameter int CLK_DIV  = 50000,
  parameter int LZ_BLANK = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value,
  input  logic [3:0]  dots,
  input  logic [3:0]  blank,
  input  logic        load,
  output logic [3:0]  digit_data,
  output logic        digit_point,
  output logic [3:0]  anodes,
  output logic        frame_done,
  output logic        pending
);

  localparam int            PW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0] cnt;
  logic [1:0]    idx;
  logic          tick;
  logic          boundary;
  logic          fd_r;

  logic [15:0]   val_p0;
  logic [3:0]    dots_p0;
  logic [3:0]    blank_p0;
  logic          vld_p0;

  logic [15:0]   val_p1;
  logic [3:0]    dots_p1;
  logic [3:0]    blank_p1;

  logic          off;

  // A digit above position 0 is suppressed when it and every higher nibble are zero.
  function automatic logic lz_off(input logic [15:0] v, input logic [1:0] i);
    return (LZ_BLANK != 0) && (i != 2'd0) && ((v >> {i, 2'b00}) == 16'd0);
  endfunction

  assign tick     = (cnt == LAST);
  assign boundary = tick && (idx == 2'd3);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      idx      <= 2'd0;
      fd_r     <= 1'b0;
      vld_p0   <= 1'b0;
      val_p0   <= 16'd0;
      dots_p0  <= 4'd0;
      blank_p0 <= 4'b1111;
      val_p1   <= 16'd0;
      dots_p1  <= 4'd0;
      blank_p1 <= 4'b1111;
    end else begin
      cnt  <= tick ? '0 : cnt + PW'(1);
      fd_r <= boundary;
      if (tick)
        idx <= idx + 2'd1;

      // p0 -> p1: staged data moves to the display only at a frame boundary
      if (boundary && vld_p0) begin
        val_p1   <= val_p0;
        dots_p1  <= dots_p0;
        blank_p1 <= blank_p0;
      end

      // input -> p0: a load in the boundary cycle keeps pending for the next frame
      if (load) begin
        val_p0   <= value;
        dots_p0  <= dots;
        blank_p0 <= blank;
        vld_p0   <= 1'b1;
      end else if (boundary) begin
        vld_p0   <= 1'b0;
      end
    end
  end

  // p1 -> outputs: combinational slot decode from registered idx and display state
  assign digit_data  = val_p1[{idx, 2'b00} +: 4];
  assign digit_point = dots_p1[idx];
  assign off         = blank_p1[idx] | lz_off(val_p1, idx);
  assign anodes      = off ? 4'b1111 : ~(4'b0001 << idx);
  assign frame_done  = fd_r;
  assign pending     = vld_p0;

endmodule

// File: tb/tb_disp_scan4.sv
// Scoreboard bench for disp_scan4: directed loads push cycle-stamped expected
// outputs; a negedge monitor pops and compares against the selected instance.
module tb_disp_scan4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = 16'd0;
  logic [3:0]  dots = 4'd0;
  logic [3:0]  blank = 4'd0;
  logic        load = 1'b0;

  logic [3:0] dd4, an4, ddl, anl, dd1, an1;
  logic       dp4, fd4, pd4, dpl, fdl, pdl, dp1, fd1, pd1;

  disp_scan4 #(.CLK_DIV(4), .LZ_BLANK(0)) dut4 (
    .clk(clk), .rst_n(rst_n), .value(value), .dots(dots), .blank(blank), .load(load),
    .digit_data(dd4), .digit_point(dp4), .anodes(an4), .frame_done(fd4), .pending(pd4));

  disp_scan4 #(.CLK_DIV(4), .LZ_BLANK(1)) dutlz (
    .clk(clk), .rst_n(rst_n), .value(value), .dots(dots), .blank(blank), .load(load),
    .digit_data(ddl), .digit_point(dpl), .anodes(anl), .frame_done(fdl), .pending(pdl));

  disp_scan4 #(.CLK_DIV(1), .LZ_BLANK(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .value(value), .dots(dots), .blank(blank), .load(load),
    .digit_data(dd1), .digit_point(dp1), .anodes(an1), .frame_done(fd1), .pending(pd1));

  always #5 clk = ~clk;

  int cyc = 0;
  int base = 0;
  int errors = 0;
  int checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Packed as {anodes, digit_data, digit_point, pending, frame_done}
  typedef struct {
    int          cyc;
    int          w;
    logic [10:0] exp;
    string       nm;
  } entry_t;

  entry_t q[$];

  task automatic push(input int t, input int w, input logic [3:0] an, input logic [3:0] dd,
                      input logic dp, input logic pend, input logic fd, input string nm);
    entry_t e;
    e.cyc = base + t;
    e.w   = w;
    e.exp = {an, dd, dp, pend, fd};
    e.nm  = nm;
    q.push_back(e);
  endtask

  // Expected outputs for slots [from,to) of the frame starting at t0; lit marks digits shown.
  task automatic exp_frame(input int t0, input int from, input int to, input int w, input int cdiv,
                           input logic [15:0] v, input logic [3:0] dp, input logic [3:0] lit,
                           input logic pend, input string nm);
    logic [3:0] sel;
    logic [3:0] an;
    int k;
    for (int n = from; n < to; n++) begin
      k   = n / cdiv;
      sel = 4'b0001 << k;
      an  = lit[k] ? ~sel : 4'b1111;
      push(t0 + n, w, an, v[4*k +: 4], dp[k], pend, (n == 0) && (t0 != 0), nm);
    end
  endtask

  always @(negedge clk) begin
    logic [10:0] got;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      entry_t e;
      e = q.pop_front();
      checks++;
      case (e.w)
        0:       got = {an4, dd4, dp4, pd4, fd4};
        1:       got = {anl, ddl, dpl, pdl, fdl};
        default: got = {an1, dd1, dp1, pd1, fd1};
      endcase
      if (e.cyc < cyc) begin
        errors++;
        $display("FAIL %s cyc=%0d not sampled in time (required at cyc %0d)", e.nm, cyc, e.cyc);
      end else if (got !== e.exp) begin
        errors++;
        $display("FAIL %s cyc=%0d got an=%b dd=%h dp=%b pend=%b fd=%b required an=%b dd=%h dp=%b pend=%b fd=%b",
                 e.nm, cyc, got[10:7], got[6:3], got[2], got[1], got[0],
                 e.exp[10:7], e.exp[6:3], e.exp[2], e.exp[1], e.exp[0]);
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    base = cyc;
  endtask

  task automatic wait_to(input int t);
    while (cyc < base + t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input int t, input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    wait_to(t);
    value = v; dots = d; blank = b; load = 1'b1;
    wait_to(t + 1);
    load = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d simulation did not finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    // Idle after reset: dark, no pending, frame_done every 16 cycles
    do_reset();
    exp_frame(0, 0, 16, 0, 4, 16'h0, 4'h0, 4'b0000, 1'b0, "idle_f0");
    exp_frame(16, 0, 16, 0, 4, 16'h0, 4'h0, 4'b0000, 1'b0, "idle_f1");
    exp_frame(32, 0, 1, 0, 4, 16'h0, 4'h0, 4'b0000, 1'b0, "idle_f2");
    wait_to(34);

    // Basic load: 1A3F with point on digit 2
    do_reset();
    push(0, 0, 4'b1111, 4'h0, 1'b0, 1'b0, 1'b0, "load_t0");
    exp_frame(0, 1, 16, 0, 4, 16'h0, 4'h0, 4'b0000, 1'b1, "load_wait");
    exp_frame(16, 0, 16, 0, 4, 16'h1A3F, 4'b0100, 4'b1111, 1'b0, "load_show");
    do_load(0, 16'h1A3F, 4'b0100, 4'b0000);
    wait_to(33);

    // Two loads in one frame: last one wins
    do_reset();
    exp_frame(0, 6, 16, 0, 4, 16'h0, 4'h0, 4'b0000, 1'b1, "lastwin_wait");
    exp_frame(16, 0, 16, 0, 4, 16'h2222, 4'h0, 4'b1111, 1'b0, "lastwin_f1");
    exp_frame(32, 0, 16, 0, 4, 16'h2222, 4'h0, 4'b1111, 1'b0, "lastwin_f2");
    do_load(2, 16'h1111, 4'h0, 4'h0);
    do_load(5, 16'h2222, 4'h0, 4'h0);
    wait_to(49);

    // Load in the boundary cycle: old staging shown first, new one a frame later
    do_reset();
    exp_frame(0, 1, 16, 0, 4, 16'h0, 4'h0, 4'b0000, 1'b1, "bnd_wait");
    exp_frame(16, 0, 16, 0, 4, 16'h4444, 4'h0, 4'b1111, 1'b1, "bnd_old");
    exp_frame(32, 0, 16, 0, 4, 16'h5555, 4'h0, 4'b1111, 1'b0, "bnd_new");
    do_load(0, 16'h4444, 4'h0, 4'h0);
    do_load(15, 16'h5555, 4'h0, 4'h0);
    wait_to(49);

    // Leading-zero blanking on the LZ instance
    do_reset();
    exp_frame(0, 1, 16, 1, 4, 16'h0, 4'h0, 4'b0000, 1'b1, "lz_wait");
    exp_frame(16, 0, 5, 1, 4, 16'h0070, 4'h0, 4'b0011, 1'b0, "lz_0070");
    exp_frame(16, 5, 16, 1, 4, 16'h0070, 4'h0, 4'b0011, 1'b1, "lz_0070p");
    exp_frame(32, 0, 16, 1, 4, 16'h0000, 4'h0, 4'b0001, 1'b0, "lz_0000");
    do_load(0, 16'h0070, 4'h0, 4'h0);
    do_load(20, 16'h0000, 4'h0, 4'h0);
    wait_to(49);

    // Mid-frame reset discards staging and restarts the prescaler
    do_reset();
    exp_frame(0, 1, 10, 0, 4, 16'h0, 4'h0, 4'b0000, 1'b1, "mrst_pre");
    do_load(0, 16'h1234, 4'h0, 4'h0);
    wait_to(9);
    do_reset();
    exp_frame(0, 0, 16, 0, 4, 16'h0, 4'h0, 4'b0000, 1'b0, "mrst_f0");
    exp_frame(16, 0, 16, 0, 4, 16'h0, 4'h0, 4'b0000, 1'b0, "mrst_f1");
    wait_to(33);

    // CLK_DIV=1: one digit per cycle, frame_done every 4 cycles
    do_reset();
    exp_frame(0, 1, 4, 2, 1, 16'h0, 4'h0, 4'b0000, 1'b1, "div1_wait");
    exp_frame(4, 0, 4, 2, 1, 16'h4321, 4'b0001, 4'b1111, 1'b0, "div1_f1");
    exp_frame(8, 0, 4, 2, 1, 16'h4321, 4'b0001, 4'b1111, 1'b0, "div1_f2");
    exp_frame(12, 0, 4, 2, 1, 16'h4321, 4'b0001, 4'b1111, 1'b0, "div1_f3");
    do_load(0, 16'h4321, 4'b0001, 4'h0);
    wait_to(18);

    @(negedge clk);
    while (q.size() > 0) begin
      entry_t e;
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s leftover got none required check at cyc %0d", e.nm, e.cyc);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/disp_scan4.md
Name: disp_scan4

Overview:
- Time-multiplexed scanner for a 4-digit common-anode 7-segment display.
- Sits directly upstream of the hex-to-7-segment decoder. Each scan slot presents one nibble and one decimal-point bit to the decoder and drives the matching digit anode.
- A new value is loaded into a staging register. It moves into the displayed register only at a frame boundary, so no frame ever mixes old and new digits.

Parameters:
- CLK_DIV, 50000, clk cycles per digit slot; legal range is 1 or more.
- LZ_BLANK, 0, 1 enables leading-zero blanking; digit 0 is never auto-blanked.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- value  input  16  four hex digits; value[3:0] is digit 0 (rightmost), value[15:12] is digit 3.
- dots  input  4  decimal-point request per digit, active-high.
- blank  input  4  forced blank per digit, active-high.
- load  input  1  one-cycle strobe; captures value, dots and blank into staging.
- digit_data  output  4  nibble for the current digit; feeds the decoder's data_in.
- digit_point  output  1  point for the current digit, active-high; feeds the decoder's point input.
- anodes  output  4  digit enables, active-low, one-hot-low when a digit is lit.
- frame_done  output  1  one-cycle pulse after each completed 4-digit frame.
- pending  output  1  high while staged data is waiting for a frame boundary.

Behaviour:
- Reset, when rst_n=0 at a clock edge:
  - prescaler=0, idx=0, pending=0, frame_done=0.
  - Staging and display value=0, dots=0, blank=4'b1111.
  - Result: anodes=4'b1111, digit_data=0, digit_point=0. The display stays dark until the first load reaches the display.
  - Reset mid-frame discards any staged data.
- Prescaler:
  - Counts 0..CLK_DIV-1 and wraps to 0.
  - tick=1 in the cycle where count==CLK_DIV-1.
  - With CLK_DIV=1, tick is 1 every cycle.
- Digit index idx (2 bits): advances on tick, 0->1->2->3->0.
  - boundary = tick AND idx==3.
- Load:
  - On load=1, staging <= {value, dots, blank} and pending <= 1.
  - With several loads before a boundary, the last one wins.
- Frame boundary:
  - At the edge where boundary=1 and pending=1: display <= staging and pending <= 0.
  - If load=1 in the same cycle as the boundary:
    - The old staging content is transferred to the display.
    - The new inputs are written into staging.
    - pending stays 1, so the new data appears one frame later.
- frame_done: registered; equals 1 in the cycle after each boundary edge, otherwise 0. It pulses every frame, whether or not a transfer happened.
- Output decode (combinational from the registered idx and display registers; no added latency):
  - digit_data = display value nibble[idx].
  - digit_point = display dots[idx].
  - off = display blank[idx] OR lz(idx).
  - lz(idx) = LZ_BLANK AND idx!=0 AND nibble[idx]==0 AND every higher nibble ==0.
  - anodes = 4'b1111 if off, else ~(4'b0001 << idx).
  - digit_data and digit_point keep their values even when the digit is off.
- Digit timing: each digit is lit for exactly CLK_DIV cycles, and one frame is 4*CLK_DIV cycles.
- load is sampled every cycle. pending is reported only on its own output; the block never applies back-pressure.

Test Plan (CLK_DIV=4 unless stated):
- Reset, then run 32 cycles with no load -> anodes=4'b1111 throughout; frame_done pulses every 16 cycles; pending=0.
- load value=16'h1A3F, dots=4'b0100, blank=0 -> pending=1 until the next boundary.
  - Then each 4-cycle slot in turn: anodes 1110/digit_data F, 1101/3, 1011/A with point=1, 0111/1.
  - pending clears at the same edge the new digits take effect.
- Load 16'h1111 then 16'h2222 in one frame -> only 2222 is ever displayed; 1111 never appears.
- load asserted in the exact boundary cycle with 16'h5555 while staging holds 16'h4444 -> the next frame shows 4444; 5555 appears one frame later; pending is 1 between.
- LZ_BLANK=1, value=16'h0070 -> digits 3 and 2 are dark (anodes=1111 in their slots), digits 1 and 0 show 7 and 0. With value=16'h0000, only digit 0 lights.
- rst_n=0 for one cycle mid-frame with pending=1 -> next cycle idx=0, pending=0, display dark, prescaler restarts at 0.
- CLK_DIV=1 -> idx changes every cycle; frame_done pulses every 4 cycles.
